// File: rtl/cache_arbiter_if.sv
// Bundle of the I-cache, D-cache and physical-memory ports around the arbiter.
// The slave modport is the arbiter's view. The master modport is the
// surrounding system's view: the two caches plus the memory.
interface cache_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic [ADDR_W-1:0] i_addr;
  logic              i_read;
  logic              i_write;
  logic [LINE_W-1:0] i_wdata256;
  logic [LINE_W-1:0] i_rdata256;
  logic              i_resp;

  logic [ADDR_W-1:0] d_addr;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata256;
  logic [LINE_W-1:0] d_rdata256;
  logic              d_resp;

  logic [ADDR_W-1:0] pmem_addr;
  logic              pmem_read;
  logic              pmem_write;
  logic [LINE_W-1:0] pmem_wdata256;
  logic [LINE_W-1:0] pmem_rdata256;
  logic              pmem_resp;

  modport slave (
    input  i_addr, i_read, i_write, i_wdata256,
    output i_rdata256, i_resp,
    input  d_addr, d_read, d_write, d_wdata256,
    output d_rdata256, d_resp,
    output pmem_addr, pmem_read, pmem_write, pmem_wdata256,
    input  pmem_rdata256, pmem_resp
  );

  modport master (
    output i_addr, i_read, i_write, i_wdata256,
    input  i_rdata256, i_resp,
    output d_addr, d_read, d_write, d_wdata256,
    input  d_rdata256, d_resp,
    input  pmem_addr, pmem_read, pmem_write, pmem_wdata256,
    output pmem_rdata256, pmem_resp
  );
endinterface

// File: rtl/cache_arbiter.sv
// Two-client (I-cache / D-cache) arbiter onto a single physical-memory port.
// One transaction is in flight at a time. Ties are broken round-robin.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a request; picks the winner and latches its request
// BUSY    | memory strobe held from the latches until pmem_resp
// RESPOND | one-cycle completion pulse to the granted client
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input logic             clk,
  input logic             rst,
  cache_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

  state_t            state, state_nxt;
  logic              gnt;        // 0 = I-cache, 1 = D-cache
  logic              last;       // client served most recently
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              op_wr_q;    // 1 = write-back, 0 = line fill
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;

  logic i_req, d_req;
  logic take, pick_d, capture;
  logic pmem_read_c, pmem_write_c, i_resp_c, d_resp_c;

  assign i_req = bus.i_read | bus.i_write;
  assign d_req = bus.d_read | bus.d_write;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, arbitration decision and strobe/response decode.
  always_comb begin
    state_nxt    = state;
    take         = 1'b0;
    pick_d       = 1'b0;
    capture      = 1'b0;
    pmem_read_c  = 1'b0;
    pmem_write_c = 1'b0;
    i_resp_c     = 1'b0;
    d_resp_c     = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          take      = 1'b1;
          // On a tie, serve whoever was not served last.
          pick_d    = d_req && (!i_req || !last);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        pmem_read_c  = ~op_wr_q;
        pmem_write_c = op_wr_q;
        if (bus.pmem_resp) begin
          capture   = 1'b1;
          state_nxt = RESPOND;
        end
      end
      RESPOND: begin
        i_resp_c  = ~gnt;
        d_resp_c  = gnt;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latches and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt     <= 1'b0;
      last    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
    end else begin
      if (take) begin
        gnt     <= pick_d;
        addr_q  <= pick_d ? bus.d_addr     : bus.i_addr;
        wdata_q <= pick_d ? bus.d_wdata256 : bus.i_wdata256;
        op_wr_q <= pick_d ? bus.d_write    : bus.i_write;
      end
      if (capture) last <= gnt;
    end
  end

  // Per-client return lines; each holds until its client's next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (capture) begin
      if (gnt) d_rdata_q <= bus.pmem_rdata256;
      else     i_rdata_q <= bus.pmem_rdata256;
    end
  end

  assign bus.pmem_addr     = addr_q;
  assign bus.pmem_wdata256 = wdata_q;
  assign bus.pmem_read     = pmem_read_c;
  assign bus.pmem_write    = pmem_write_c;
  assign bus.i_resp        = i_resp_c;
  assign bus.d_resp        = d_resp_c;
  assign bus.i_rdata256    = i_rdata_q;
  assign bus.d_rdata256    = d_rdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: reset, single read, write-back,
// round-robin fairness, reset abort and stray memory responses.
module tb_cache_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  cache_arbiter_if bus ();

  cache_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] LINE_A5  = {32{8'hA5}};
  localparam logic [255:0] PATTERN  = {4{64'h0123_4567_89AB_CDEF}};
  localparam logic [255:0] LINE_X1  = {8{32'h1111_0001}};
  localparam logic [255:0] LINE_Y   = {8{32'h7E57_0042}};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkl(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus.i_addr        = '0;
    bus.i_read        = 1'b1;
    bus.i_write       = 1'b0;
    bus.i_wdata256    = '0;
    bus.d_addr        = '0;
    bus.d_read        = 1'b1;
    bus.d_write       = 1'b0;
    bus.d_wdata256    = '0;
    bus.pmem_rdata256 = '0;
    bus.pmem_resp     = 1'b0;

    // Reset held two cycles with both clients requesting.
    cyc();
    cyc();
    chk1("rst_pmem_read",  bus.pmem_read,  1'b0);
    chk1("rst_pmem_write", bus.pmem_write, 1'b0);
    chk1("rst_i_resp",     bus.i_resp,     1'b0);
    chk1("rst_d_resp",     bus.d_resp,     1'b0);
    chka("rst_pmem_addr",  bus.pmem_addr,  32'h0);
    chkl("rst_pmem_wdata", bus.pmem_wdata256, '0);
    chkl("rst_i_rdata",    bus.i_rdata256, '0);
    chkl("rst_d_rdata",    bus.d_rdata256, '0);

    // First tie after reset goes to D; requester drops while BUSY.
    bus.i_addr = 32'h0000_1000;
    bus.d_addr = 32'h0000_2000;
    rst = 1'b0;
    cyc();
    chka("tie0_addr", bus.pmem_addr, 32'h0000_2000);
    chk1("tie0_read", bus.pmem_read, 1'b1);
    bus.i_read = 1'b0;
    bus.d_read = 1'b0;
    bus.pmem_rdata256 = LINE_X1;
    bus.pmem_resp = 1'b1;
    cyc();
    chk1("tie0_d_resp", bus.d_resp, 1'b1);
    chk1("tie0_i_resp", bus.i_resp, 1'b0);
    chkl("tie0_d_rdata", bus.d_rdata256, LINE_X1);
    chk1("tie0_read_off", bus.pmem_read, 1'b0);
    bus.pmem_resp = 1'b0;
    cyc();
    chk1("tie0_d_resp_end", bus.d_resp, 1'b0);

    // Single I read, memory answers in the fifth strobe cycle.
    bus.i_addr = 32'h0000_1000;
    bus.i_read = 1'b1;
    cyc();
    bus.i_read = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      chk1("iread_strobe", bus.pmem_read, 1'b1);
      chka("iread_addr", bus.pmem_addr, 32'h0000_1000);
      chk1("iread_d_resp", bus.d_resp, 1'b0);
      if (c == 5) begin
        bus.pmem_rdata256 = LINE_A5;
        bus.pmem_resp = 1'b1;
      end
      cyc();
    end
    chk1("iread_i_resp", bus.i_resp, 1'b1);
    chk1("iread_d_resp_rsp", bus.d_resp, 1'b0);
    chkl("iread_i_rdata", bus.i_rdata256, LINE_A5);
    chkl("iread_d_rdata_hold", bus.d_rdata256, LINE_X1);
    chk1("iread_read_off", bus.pmem_read, 1'b0);
    bus.pmem_resp = 1'b0;
    bus.pmem_rdata256 = '0;
    cyc();
    chk1("iread_i_resp_end", bus.i_resp, 1'b0);
    chkl("iread_i_rdata_hold", bus.i_rdata256, LINE_A5);

    // D write-back; inputs changed during BUSY must be ignored.
    bus.d_addr = 32'h8000_0040;
    bus.d_write = 1'b1;
    bus.d_wdata256 = PATTERN;
    cyc();
    chk1("wb_write", bus.pmem_write, 1'b1);
    chk1("wb_read",  bus.pmem_read,  1'b0);
    chka("wb_addr",  bus.pmem_addr,  32'h8000_0040);
    chkl("wb_wdata", bus.pmem_wdata256, PATTERN);
    bus.d_write = 1'b0;
    bus.d_wdata256 = '0;
    bus.d_addr = 32'h0;
    cyc();
    chkl("wb_wdata_held", bus.pmem_wdata256, PATTERN);
    chka("wb_addr_held",  bus.pmem_addr,  32'h8000_0040);
    chk1("wb_write_held", bus.pmem_write, 1'b1);
    bus.pmem_resp = 1'b1;
    cyc();
    chk1("wb_d_resp", bus.d_resp, 1'b1);
    chk1("wb_i_resp", bus.i_resp, 1'b0);
    chk1("wb_write_off", bus.pmem_write, 1'b0);
    bus.pmem_resp = 1'b0;
    cyc();
    chk1("wb_d_resp_end", bus.d_resp, 1'b0);

    // Fairness: fresh reset, both reading continuously -> D, I, D, I.
    rst = 1'b1;
    bus.i_addr = 32'h0000_0100;
    bus.d_addr = 32'h0000_0200;
    bus.i_read = 1'b1;
    bus.d_read = 1'b1;
    cyc();
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      cyc();
      chka("rr_addr", bus.pmem_addr, (t % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100);
      chk1("rr_read", bus.pmem_read, 1'b1);
      bus.pmem_resp = 1'b1;
      cyc();
      chk1("rr_d_resp", bus.d_resp, (t % 2 == 0));
      chk1("rr_i_resp", bus.i_resp, (t % 2 == 1));
      bus.pmem_resp = 1'b0;
      if (t == 3) begin
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
      end
      cyc();
    end
    chk1("rr_idle_read", bus.pmem_read, 1'b0);

    // Abort: reset two cycles into a BUSY D read.
    bus.d_addr = 32'h0000_3000;
    bus.d_read = 1'b1;
    cyc();
    chk1("abort_busy1", bus.pmem_read, 1'b1);
    bus.d_read = 1'b0;
    cyc();
    chk1("abort_busy2", bus.pmem_read, 1'b1);
    rst = 1'b1;
    cyc();
    chk1("abort_read_off", bus.pmem_read, 1'b0);
    chk1("abort_d_resp", bus.d_resp, 1'b0);
    rst = 1'b0;
    bus.pmem_resp = 1'b1;
    cyc();
    chk1("abort_late_d_resp", bus.d_resp, 1'b0);
    chk1("abort_late_read", bus.pmem_read, 1'b0);
    bus.pmem_resp = 1'b0;
    bus.i_addr = 32'h0000_4000;
    bus.i_read = 1'b1;
    cyc();
    chka("post_abort_addr", bus.pmem_addr, 32'h0000_4000);
    chk1("post_abort_read", bus.pmem_read, 1'b1);
    bus.i_read = 1'b0;
    bus.pmem_rdata256 = LINE_Y;
    bus.pmem_resp = 1'b1;
    cyc();
    chk1("post_abort_i_resp", bus.i_resp, 1'b1);
    chk1("post_abort_d_resp", bus.d_resp, 1'b0);
    chkl("post_abort_i_rdata", bus.i_rdata256, LINE_Y);
    // pmem_resp left high: RESPOND and IDLE must ignore it.
    cyc();
    chk1("held_resp_i_resp", bus.i_resp, 1'b0);
    chk1("held_resp_read", bus.pmem_read, 1'b0);

    // Stray response in IDLE with no requests.
    for (int s = 0; s < 3; s++) begin
      cyc();
      chk1("stray_i_resp", bus.i_resp, 1'b0);
      chk1("stray_d_resp", bus.d_resp, 1'b0);
      chk1("stray_read",   bus.pmem_read, 1'b0);
      chk1("stray_write",  bus.pmem_write, 1'b0);
    end
    bus.pmem_resp = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
